// File: rtl/pipe_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exec_ctrl
// Description : Run/step/halt sequencer for the 5-stage pipelined core.
//               Conditions the run switch and step button (2-flop sync plus
//               debounce), drives pipeline/PC enables, IF bubble and flush,
//               drains in-flight instructions on HALT and then freezes.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_exec_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PIPE_DEPTH      = 5,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    input  logic             step,
    input  logic             halt_id,
    input  logic             stall_req,
    output logic             pipe_en,
    output logic             pc_en,
    output logic             if_bubble,
    output logic             flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int c_DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int c_DRAIN_W = (PIPE_DEPTH < 3) ? 1 : $clog2(PIPE_DEPTH);

    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(PIPE_DEPTH - 2);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_DRAIN_W-1:0]  r_drain_cnt;
    logic                  w_drain_load;
    logic                  r_flush;
    logic                  w_flush_nxt;
    logic [CNT_W-1:0]      r_cycle_cnt;

    // Bit 0 carries the run switch, bit 1 the step button.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_db;
    logic [1:0]            r_db_q;
    logic [c_DB_W-1:0]     r_db_cnt [2];

    logic                  w_db_sw;
    logic                  w_sw_fall;
    logic                  w_step_pulse;
    logic                  w_halt_go;

    assign w_raw        = {step, sw};
    assign w_db_sw      = r_db[0];
    assign w_sw_fall    = ~r_db[0] & r_db_q[0];
    assign w_step_pulse = r_db[1] & ~r_db_q[1];
    // A HALT held behind a load-use stall is not yet acted on.
    assign w_halt_go    = halt_id & ~stall_req;

    // Synchronize both pins, then flip the debounced value only after a run
    // of DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == c_DB_LAST) begin
                        r_db[i]     <= ~r_db[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Sequencer state, drain countdown and the registered flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= w_flush_nxt;
            if (w_drain_load) begin
                r_drain_cnt <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
        end
    end

    // Next-state selection; HALT outranks the run switch dropping.
    always_comb begin
        w_state_nxt  = r_state;
        w_drain_load = 1'b0;
        w_flush_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_db_sw) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_pulse) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (w_halt_go) begin
                    w_state_nxt  = S_DRAIN;
                    w_drain_load = 1'b1;
                end else if (!w_db_sw) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (w_halt_go) begin
                    w_state_nxt  = S_DRAIN;
                    w_drain_load = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (w_sw_fall) begin
                    w_state_nxt = S_IDLE;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pipeline control outputs decoded from the current state and hazards.
    always_comb begin
        pipe_en   = 1'b0;
        pc_en     = 1'b0;
        if_bubble = 1'b0;
        unique case (r_state)
            S_RUN, S_STEP: begin
                pipe_en   = 1'b1;
                pc_en     = ~stall_req & ~halt_id;
                if_bubble = w_halt_go;
            end
            S_DRAIN: begin
                pipe_en   = 1'b1;
                if_bubble = 1'b1;
            end
            default: begin
                pipe_en   = 1'b0;
            end
        endcase
    end

    // Active-cycle counter: saturating, cleared by the flush pulse.
    always_ff @(posedge clk) begin
        if (rst || r_flush) begin
            r_cycle_cnt <= '0;
        end else if (pipe_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign flush     = r_flush;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_exec_ctrl
// Description : Self-checking bench for pipe_exec_ctrl: directed scenarios
//               plus randomized pins against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_exec_ctrl;

    localparam int c_D     = 4;
    localparam int c_DEPTH = 5;
    localparam int c_CW    = 6;
    localparam int c_MAX   = (1 << c_CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            sw;
    logic            step;
    logic            halt_id;
    logic            stall_req;
    logic            pipe_en;
    logic            pc_en;
    logic            if_bubble;
    logic            flush;
    logic [2:0]      state;
    logic [c_CW-1:0] cycle_cnt;

    int n_vec = 0;
    int n_bad = 0;

    pipe_exec_ctrl #(
        .DEBOUNCE_CYCLES (c_D),
        .PIPE_DEPTH      (c_DEPTH),
        .CNT_W           (c_CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .step      (step),
        .halt_id   (halt_id),
        .stall_req (stall_req),
        .pipe_en   (pipe_en),
        .pc_en     (pc_en),
        .if_bubble (if_bubble),
        .flush     (flush),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    bit m_valid = 0;
    int m_mode, m_left, m_cnt;
    bit m_flush;
    bit m_db [2];
    bit m_dbp[2];
    // pin history per input: index 0 oldest ... c_D+1 newest (last edge)
    bit m_hist[2][c_D+2];

    function automatic bit e_pipe(int md);
        return (md == 1) || (md == 2) || (md == 3);
    endfunction
    function automatic bit e_pc(int md, bit h, bit s);
        return ((md == 1) || (md == 2)) && !h && !s;
    endfunction
    function automatic bit e_bub(int md, bit h, bit s);
        return (((md == 1) || (md == 2)) && h && !s) || (md == 3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_mode  = 0;
            m_left  = 0;
            m_flush = 0;
            m_cnt   = 0;
            for (int k = 0; k < 2; k++) begin
                m_db[k]  = 0;
                m_dbp[k] = 0;
                for (int j = 0; j < c_D + 2; j++) m_hist[k][j] = 0;
            end
        end else if (m_valid) begin
            bit pe, nf, spulse, sfall, go, alldiff;
            bit pins[2];
            pins[0] = sw;
            pins[1] = step;
            pe      = e_pipe(m_mode);
            nf      = 0;
            spulse  = m_db[1] && !m_dbp[1];
            sfall   = !m_db[0] && m_dbp[0];
            go      = halt_id && !stall_req;
            case (m_mode)
                0: if (m_db[0]) m_mode = 1; else if (spulse) m_mode = 2;
                1: if (go) begin m_mode = 3; m_left = c_DEPTH - 2; end
                   else if (!m_db[0]) m_mode = 0;
                2: if (go) begin m_mode = 3; m_left = c_DEPTH - 2; end
                   else m_mode = 0;
                3: begin m_left--; if (m_left == 0) m_mode = 4; end
                default: if (sfall) begin m_mode = 0; nf = 1; end
            endcase
            if (m_flush) m_cnt = 0;
            else if (pe && m_cnt < c_MAX) m_cnt++;
            m_flush = nf;
            // synchronized sample seen at an edge = pin from two edges back;
            // debounced value flips once the last c_D of them all disagree
            for (int k = 0; k < 2; k++) begin
                m_dbp[k] = m_db[k];
                alldiff = 1;
                for (int j = 1; j <= c_D; j++)
                    if (m_hist[k][j] == m_db[k]) alldiff = 0;
                if (alldiff) m_db[k] = !m_db[k];
                for (int j = 0; j < c_D + 1; j++) m_hist[k][j] = m_hist[k][j+1];
                m_hist[k][c_D+1] = pins[k];
            end
        end
    end

    // single compare process: every cycle once the model is initialized
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",     32'(state),     32'(m_mode));
            chk("pipe_en",   32'(pipe_en),   32'(e_pipe(m_mode)));
            chk("pc_en",     32'(pc_en),     32'(e_pc(m_mode, halt_id, stall_req)));
            chk("if_bubble", 32'(if_bubble), 32'(e_bub(m_mode, halt_id, stall_req)));
            chk("flush",     32'(flush),     32'(m_flush));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, nstep, hold_sw, hold_st;
        bit seen;
        rst = 1; sw = 0; step = 0; halt_id = 0; stall_req = 0;
        repeat (3) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        chk("rst_pipe", 32'(pipe_en), 0);
        rst = 0;

        // switch latency: RUN after the 7th edge, first count after the 8th
        sw = 1;
        repeat (6) tick();
        chk("lat_idle", 32'(state), 0);
        tick();
        chk("lat_run", 32'(state), 1);
        chk("lat_pc", 32'(pc_en), 1);
        tick();
        chk("lat_cnt", 32'(cycle_cnt), 1);
        repeat (3) tick();

        // HALT behind a 2-cycle stall, then drain and freeze
        halt_id = 1; stall_req = 1;
        tick();
        chk("stall1_state", 32'(state), 1);
        chk("stall1_pc", 32'(pc_en), 0);
        tick();
        chk("stall2_state", 32'(state), 1);
        chk("stall2_bub", 32'(if_bubble), 0);
        stall_req = 0;
        #1;
        chk("halt_pc", 32'(pc_en), 0);
        chk("halt_bub", 32'(if_bubble), 1);
        tick();
        halt_id = 0;
        chk("drain1", 32'(state), 3);
        chk("drain_bub", 32'(if_bubble), 1);
        chk("drain_pc", 32'(pc_en), 0);
        repeat (2) tick();
        chk("drain3", 32'(state), 3);
        tick();
        chk("halted", 32'(state), 4);
        chk("halted_pipe", 32'(pipe_en), 0);

        // switch off in HALTED: one flush pulse, counter cleared
        sw = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (flush) seen = 1;
        end
        chk("flush_seen", 32'(seen), 1);
        chk("flush_state", 32'(state), 0);
        tick();
        chk("flush_once", 32'(flush), 0);
        chk("flush_cnt", 32'(cycle_cnt), 0);

        // 3-cycle glitch never gets through the debouncer
        sw = 1;
        repeat (3) tick();
        sw = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state != 0 || pipe_en) seen = 1;
        end
        chk("glitch_idle", 32'(seen), 0);

        // two held step presses: one STEP cycle each
        base = cycle_cnt;
        for (int p = 1; p <= 2; p++) begin
            nstep = 0;
            step = 1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (state == 2) nstep++;
            end
            step = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (state == 2) nstep++;
            end
            chk("step_cycles", 32'(nstep), 1);
            chk("step_cnt", 32'(cycle_cnt), 32'(base + p));
        end

        // long run saturates the counter
        sw = 1;
        repeat (90) tick();
        chk("sat_cnt", 32'(cycle_cnt), c_MAX);

        // reset in the middle of a drain aborts everything
        halt_id = 1;
        tick();
        halt_id = 0;
        chk("rd_drain", 32'(state), 3);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rd_state", 32'(state), 0);
        chk("rd_pipe", 32'(pipe_en), 0);
        chk("rd_bub", 32'(if_bubble), 0);
        chk("rd_cnt", 32'(cycle_cnt), 0);
        repeat (6) tick();
        chk("rd_idle", 32'(state), 0);
        tick();
        chk("rd_run", 32'(state), 1);

        // randomized pins, checked cycle by cycle against the model
        hold_sw = 0;
        hold_st = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_sw == 0) begin
                sw = 1'($urandom_range(0, 1));
                hold_sw = $urandom_range(1, 14);
            end else hold_sw--;
            if (hold_st == 0) begin
                step = 1'($urandom_range(0, 1));
                hold_st = $urandom_range(1, 12);
            end else hold_st--;
            halt_id   = ($urandom_range(0, 15) == 0);
            stall_req = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; halt_id = 0; stall_req = 0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
